sid_mixer: RTL and testbench
============================

Name: sid_mixer

Overview:
Output mixer/volume stage directly downstream of the state-variable filter. It sums the selected filter outputs (LP/BP/HP) with the unfiltered voice paths, applying the SID mode/volume register ($18). It saturates the sum to 16 bits, then scales it by the 4-bit master volume. It runs as a short sequential accumulate pipeline once per sample, triggered by the same clkEn sample strobe as the filter, and produces one registered audio sample plus a valid pulse per strobe.

Parameters:
ACC_W, 19, accumulator width in bits; must hold 5 x signed 16-bit terms without overflow.
VOL_SHIFT, 4, right shift applied after the volume multiply (volume 15 gives a gain of 15/16).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
clkEn  in  1  sample strobe; starts one mix sequence
iLP  in  16  signed filter low-pass output
iBP  in  16  signed filter band-pass output
iHP  in  16  signed filter high-pass output
iDirect  in  16  signed sum of unfiltered voices 1/2 (filter bypass path)
iVoice3  in  16  signed unfiltered voice 3
WR  in  1  register write strobe
ADDR  in  5  register address bus
DATA  in  8  register data bus
oOut  out  16  signed mixed, volume-scaled sample
oValid  out  1  one-cycle pulse when oOut updates

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - oOut=0, oValid=0, state=IDLE, accumulator=0.
  - Mode register=8'h00 (all filter outputs off, 3OFF clear, volume 0).
  - Snapshot registers=0.
- Register decode: WR && ADDR==5'h18 writes modeReg<=DATA.
  - Bit 7 = 3OFF, bit 6 = HP enable, bit 5 = BP enable, bit 4 = LP enable, bits 3:0 = volume.
  - Other addresses are ignored.
- Snapshot at clkEn (edge N):
  - Latch iLP/iBP/iHP/iDirect/iVoice3 and modeReg into snapshot registers.
  - Clear the accumulator; state<=ACC0; oValid<=0.
  - Register writes after edge N affect only the next sample.
- Sequence (one step per clock, no waits):
  - N+1 ACC0: acc += LP if LP enabled, else +0.
  - N+2 ACC1: acc += BP if enabled.
  - N+3 ACC2: acc += HP if enabled.
  - N+4 ACC3: acc += iDirect (always).
  - N+5 ACC4: acc += iVoice3 unless 3OFF.
  - N+6 SAT: sat <= clamp(acc, -32768, 32767).
  - N+7 SCALE: oOut <= (sat * vol) >>> VOL_SHIFT; oValid<=1.
  - N+8 IDLE: oValid<=0.
- Latency: oValid is high in the single cycle following edge N+7, i.e. 7 clocks after the strobe edge. oOut holds its value until the next SCALE.
- Arithmetic:
  - All inputs sign-extended to ACC_W.
  - Volume is unsigned 4-bit, zero-extended.
  - Product is 21-bit signed; arithmetic right shift truncates toward minus infinity.
  - vol=0 always yields 0.
- clkEn while busy (state != IDLE): abort the current sequence and restart from the snapshot at that edge. The aborted sample produces no oValid.
- clkEn in the same cycle as a $18 write: the snapshot takes the old modeReg; the new value is used from the next strobe.
- rst mid-sequence: everything returns to reset values immediately. No oValid until a fresh clkEn completes a sequence.
- clkEn spacing of 8 or more clocks guarantees one oValid per strobe.

Test Plan:
1. Reset: assert rst mid-run -> oOut=0, oValid=0 at once. A strobe with modeReg=0 and iDirect=1000 -> oOut=0 (volume 0), oValid pulse 7 clocks after the strobe.
2. LP only: write $18=8'h1F; iLP=1000, others 0; clkEn -> oOut=937, exactly one oValid pulse.
3. Positive saturation: $18=8'h7F; all five inputs=32767 -> sat=32767, oOut=30719.
4. Negative saturation: $18=8'h7F; all inputs=-32768 -> oOut=-30720.
5. 3OFF: $18=8'h8F; iVoice3=10000, iDirect=0 -> oOut=0. Then $18=8'h0F -> oOut=9375.
6. Restart/ordering:
   - clkEn again 3 clocks after the first strobe -> only one oValid, carrying the second snapshot.
   - Write $18 volume 15->8 at N+2 -> that sample still uses 15; the next sample uses 8 (iDirect=1600 -> 800).

Source files
------------

// File: rtl/sid_mixer_if.sv
// Bundle of the sample-path, register-bus and output signals of the SID output mixer.
// clkEn is a one-cycle strobe with no back-pressure. oValid pulses for one cycle when oOut takes a new sample.
interface sid_mixer_if;
    logic               clkEn;
    logic signed [15:0] iLP;
    logic signed [15:0] iBP;
    logic signed [15:0] iHP;
    logic signed [15:0] iDirect;
    logic signed [15:0] iVoice3;
    logic               WR;
    logic [4:0]         ADDR;
    logic [7:0]         DATA;
    logic signed [15:0] oOut;
    logic               oValid;
    logic [2:0]         state;

    modport master (
        output clkEn, iLP, iBP, iHP, iDirect, iVoice3, WR, ADDR, DATA,
        input  oOut, oValid, state
    );

    modport slave (
        input  clkEn, iLP, iBP, iHP, iDirect, iVoice3, WR, ADDR, DATA,
        output oOut, oValid, state
    );
endinterface

// File: rtl/sid_mixer.sv
// SID output mixer: sequentially sums the enabled filter taps and voice paths, saturates the sum to 16 bits,
// then applies the 4-bit master volume. One accumulate step per clock after each sample strobe.
module sid_mixer #(
    parameter int ACC_W     = 19,
    parameter int VOL_SHIFT = 4
) (
    input logic         clk,
    input logic         rst,
    sid_mixer_if.slave  bus
);
    localparam logic [4:0] MODE_ADDR = 5'h18;
    localparam int         PROD_W    = 21;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ACC0  = 3'd1;
    localparam logic [2:0] ACC1  = 3'd2;
    localparam logic [2:0] ACC2  = 3'd3;
    localparam logic [2:0] ACC3  = 3'd4;
    localparam logic [2:0] ACC4  = 3'd5;
    localparam logic [2:0] SAT   = 3'd6;
    localparam logic [2:0] SCALE = 3'd7;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(32768));

    logic [7:0]               mode_reg;
    logic [7:0]               snap_mode;
    logic signed [15:0]       snap_lp;
    logic signed [15:0]       snap_bp;
    logic signed [15:0]       snap_hp;
    logic signed [15:0]       snap_direct;
    logic signed [15:0]       snap_voice3;
    logic [2:0]               state;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  addend;
    logic signed [15:0]       sat;
    logic signed [15:0]       clamped;
    logic signed [PROD_W-1:0] product;
    logic signed [15:0]       scaled;
    logic signed [15:0]       out_q;
    logic                     valid_q;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [15:0] x);
        return {{(ACC_W-16){x[15]}}, x};
    endfunction

    // Each accumulate state contributes one term; a disabled path adds zero so the sequence length never changes.
    always_comb begin
        addend = '0;
        case (state)
            ACC0:    if (snap_mode[4])  addend = sext(snap_lp);
            ACC1:    if (snap_mode[5])  addend = sext(snap_bp);
            ACC2:    if (snap_mode[6])  addend = sext(snap_hp);
            ACC3:                       addend = sext(snap_direct);
            ACC4:    if (!snap_mode[7]) addend = sext(snap_voice3);
            default:                    addend = '0;
        endcase
    end

    always_comb begin
        clamped = acc[15:0];
        if (acc > SAT_MAX)      clamped = 16'sh7fff;
        else if (acc < SAT_MIN) clamped = 16'sh8000;
    end

    // Volume is zero-extended; the low 21 bits of the product are identical for signed and unsigned operands.
    assign product = $signed({{(PROD_W-16){sat[15]}}, sat} * {{(PROD_W-4){1'b0}}, snap_mode[3:0]});
    assign scaled  = 16'(product >>> VOL_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg <= 8'h00;
        end else if (bus.WR && bus.ADDR == MODE_ADDR) begin
            mode_reg <= bus.DATA;
        end
    end

    // A strobe always wins: it restarts from a fresh snapshot even mid-sequence, so an aborted sample never pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            sat         <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            snap_mode   <= '0;
            snap_lp     <= '0;
            snap_bp     <= '0;
            snap_hp     <= '0;
            snap_direct <= '0;
            snap_voice3 <= '0;
        end else begin
            valid_q <= 1'b0;
            if (bus.clkEn) begin
                snap_mode   <= mode_reg;
                snap_lp     <= bus.iLP;
                snap_bp     <= bus.iBP;
                snap_hp     <= bus.iHP;
                snap_direct <= bus.iDirect;
                snap_voice3 <= bus.iVoice3;
                acc         <= '0;
                state       <= ACC0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    ACC0: begin acc <= acc + addend; state <= ACC1; end
                    ACC1: begin acc <= acc + addend; state <= ACC2; end
                    ACC2: begin acc <= acc + addend; state <= ACC3; end
                    ACC3: begin acc <= acc + addend; state <= ACC4; end
                    ACC4: begin acc <= acc + addend; state <= SAT;  end
                    SAT: begin
                        sat   <= clamped;
                        state <= SCALE;
                    end
                    SCALE: begin
                        out_q   <= scaled;
                        valid_q <= 1'b1;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.oOut   = out_q;
    assign bus.oValid = valid_q;
    assign bus.state  = state;
endmodule

// File: tb/tb_sid_mixer.sv
// Bench for sid_mixer: fixed vectors, hand-built restart/ordering/reset sequences and random samples
// against an arithmetic model of the mix, clamp and volume rules.
module tb_sid_mixer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    sid_mixer_if bus();

    sid_mixer #(.ACC_W(19), .VOL_SHIFT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]         mode;
        logic signed [15:0] lp;
        logic signed [15:0] bp;
        logic signed [15:0] hp;
        logic signed [15:0] dir;
        logic signed [15:0] v3;
        logic signed [15:0] exp_out;
    } vec_t;

    vec_t               vecs[$];
    logic [15:0]        exp_q[$];
    int                 compared = 0;
    int                 mismatched = 0;
    logic [7:0]         rm;
    logic signed [15:0] rv[5];

    task automatic check(input string name, input int act, input int exp_v);
        compared++;
        if (act != exp_v) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Scoreboard: every oValid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.oValid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_valid: got oOut %0d with no sample outstanding at %0t",
                         $signed(bus.oOut), $time);
            end else begin
                check("oOut", int'($signed(bus.oOut)), int'($signed(exp_q.pop_front())));
            end
        end
    end

    // Mix model: sum enabled terms, clamp, multiply by volume, floor-divide by 16.
    function automatic logic [15:0] model(input logic [7:0] mode, input int lp, input int bp,
                                          input int hp, input int dir, input int v3);
        int s;
        int p;
        int q;
        s = dir;
        if (mode[4])  s += lp;
        if (mode[5])  s += bp;
        if (mode[6])  s += hp;
        if (!mode[7]) s += v3;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        p = s * int'(mode[3:0]);
        q = p / 16;
        if (p < 0 && (p % 16) != 0) q -= 1;
        return 16'(q);
    endfunction

    function automatic vec_t mk(input logic [7:0] mode, input int lp, input int bp, input int hp,
                                input int dir, input int v3, input int e);
        vec_t v;
        v.mode = mode; v.lp = 16'(lp); v.bp = 16'(bp); v.hp = 16'(hp);
        v.dir = 16'(dir); v.v3 = 16'(v3); v.exp_out = 16'(e);
        return v;
    endfunction

    task automatic write_mode(input logic [4:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.WR = 1'b1; bus.ADDR = addr; bus.DATA = data;
        @(negedge clk);
        bus.WR = 1'b0;
    endtask

    task automatic apply(input logic signed [15:0] lp, input logic signed [15:0] bp,
                         input logic signed [15:0] hp, input logic signed [15:0] dir,
                         input logic signed [15:0] v3);
        bus.iLP = lp; bus.iBP = bp; bus.iHP = hp; bus.iDirect = dir; bus.iVoice3 = v3;
    endtask

    // Returns at the falling edge just after the strobe's rising edge.
    task automatic strobe();
        @(negedge clk);
        bus.clkEn = 1'b1;
        @(negedge clk);
        bus.clkEn = 1'b0;
    endtask

    // k counts falling edges after the strobe edge; the pulse belongs at k == 7.
    task automatic watch(input string name, input logic [15:0] e, input int k0);
        int n;
        int first;
        n = 0;
        first = -1;
        exp_q.push_back(e);
        for (int k = k0; k <= 9; k++) begin
            if (bus.oValid) begin
                n++;
                if (first < 0) first = k;
            end
            @(negedge clk);
        end
        check({name, "_pulses"}, n, 1);
        check({name, "_latency"}, first, 7);
    endtask

    task automatic run_sample(input string name, input vec_t v);
        write_mode(5'h18, v.mode);
        apply(v.lp, v.bp, v.hp, v.dir, v.v3);
        strobe();
        watch(name, v.exp_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        bus.clkEn = 1'b0; bus.WR = 1'b0; bus.ADDR = '0; bus.DATA = '0;
        apply(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_oOut", int'($signed(bus.oOut)), 0);
        check("reset_oValid", int'(bus.oValid), 0);
        check("reset_state", int'(bus.state), 0);
        rst = 1'b0;

        // Volume 0 straight out of reset.
        run_sample("reset_vol0", mk(8'h00, 0, 0, 0, 1000, 0, 0));

        vecs.push_back(mk(8'h1F, 1000, 0, 0, 0, 0, 937));
        vecs.push_back(mk(8'h7F, 32767, 32767, 32767, 32767, 32767, 30719));
        vecs.push_back(mk(8'h7F, -32768, -32768, -32768, -32768, -32768, -30720));
        vecs.push_back(mk(8'h8F, 0, 0, 0, 0, 10000, 0));
        vecs.push_back(mk(8'h0F, 0, 0, 0, 0, 10000, 9375));
        vecs.push_back(mk(8'h0F, 0, 0, 0, -1000, 0, -938));
        vecs.push_back(mk(8'h1F, 1000, 500, 300, 0, 0, 937));
        vecs.push_back(mk(8'h2F, 7, -16, 9, 0, 0, -15));
        vecs.push_back(mk(8'h4F, 5, 5, 16, 0, 0, 15));
        vecs.push_back(mk(8'h18, 100, 0, 0, 1600, 0, 850));
        vecs.push_back(mk(8'h71, 1, 1, 1, -20, 0, -2));
        vecs.push_back(mk(8'h70, 30000, 30000, 30000, 30000, 30000, 0));
        vecs.push_back(mk(8'h01, 0, 0, 0, 16, 0, 1));
        foreach (vecs[i]) run_sample($sformatf("vec%0d", i), vecs[i]);

        // Second strobe 3 clocks after the first: only the second snapshot may come out.
        write_mode(5'h18, 8'h0F);
        apply(0, 0, 0, 1000, 0);
        strobe();
        check("restart_idle_k0", int'(bus.oValid), 0);
        @(negedge clk);
        @(negedge clk);
        bus.iDirect = 16'sd2000;
        bus.clkEn = 1'b1;
        @(negedge clk);
        bus.clkEn = 1'b0;
        watch("restart", 16'd1875, 0);

        // Volume change two clocks into a sample only reaches the following sample.
        apply(0, 0, 0, 1600, 0);
        strobe();
        @(negedge clk);
        bus.WR = 1'b1; bus.ADDR = 5'h18; bus.DATA = 8'h08;
        @(negedge clk);
        bus.WR = 1'b0;
        watch("midwrite", 16'd1500, 2);
        strobe();
        watch("after_midwrite", 16'd800, 0);

        // Write coinciding with the strobe: snapshot keeps the old volume.
        write_mode(5'h18, 8'h0F);
        @(negedge clk);
        bus.WR = 1'b1; bus.ADDR = 5'h18; bus.DATA = 8'h08; bus.clkEn = 1'b1;
        @(negedge clk);
        bus.WR = 1'b0; bus.clkEn = 1'b0;
        watch("samecycle", 16'd1500, 0);
        strobe();
        watch("after_samecycle", 16'd800, 0);

        // Writes to other addresses leave the mode register alone.
        write_mode(5'h18, 8'h0F);
        write_mode(5'h17, 8'h00);
        write_mode(5'h08, 8'h01);
        strobe();
        watch("other_addr", 16'd1500, 0);

        // Reset mid-sequence clears outputs without a clock edge and kills the pending sample.
        apply(0, 0, 0, 1000, 0);
        strobe();
        watch("pre_reset", 16'd937, 0);
        strobe();
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_oOut", int'($signed(bus.oOut)), 0);
        check("midrst_oValid", int'(bus.oValid), 0);
        check("midrst_state", int'(bus.state), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        strobe();
        watch("post_reset_vol0", 16'd0, 0);

        for (int it = 0; it < 40; it++) begin
            rm = 8'($urandom_range(0, 255));
            for (int j = 0; j < 5; j++) begin
                if ($urandom_range(0, 3) == 0)
                    rv[j] = ($urandom_range(0, 1) == 1) ? 16'sh7fff : 16'sh8000;
                else
                    rv[j] = 16'($urandom);
            end
            run_sample($sformatf("rand%0d", it),
                       mk(rm, rv[0], rv[1], rv[2], rv[3], rv[4],
                          int'($signed(model(rm, rv[0], rv[1], rv[2], rv[3], rv[4])))));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
